// File: rtl/joypad_poller.sv
// I2C master that sweeps NUM_PADS joypad port expanders and publishes inverted (active-high) button words.
// One tick every CLK_DIV cycles moves the bus one quarter-bit; a slave holding SCL low freezes the sample phase.
module joypad_poller #(
    parameter int       CLK_DIV       = 250,
    parameter int       NUM_PADS      = 2,
    parameter bit [6:0] BASE_ADDR     = 7'h20,
    parameter int       BYTES_PER_PAD = 1,
    parameter int       POLL_PERIOD   = 200000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                scl_in,
    input  logic                                sda_in,
    output logic                                scl_out,
    output logic                                sda_out,
    output logic [NUM_PADS*8*BYTES_PER_PAD-1:0] buttons,
    output logic [NUM_PADS-1:0]                 present,
    output logic                                valid,
    output logic                                busy
);
    localparam int W     = 8 * BYTES_PER_PAD;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW    = $clog2(POLL_PERIOD);
    localparam int IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_RD, S_MACK, S_STOP, S_NEXT
    } state_t;

    state_t                r_state;
    logic [1:0]            r_ph;
    logic [2:0]            r_bit;
    logic                  r_byte;
    logic [IDX_W-1:0]      r_idx;
    logic [DIV_W-1:0]      r_div;
    logic [TW-1:0]         r_timer;
    logic [W-1:0]          r_sr;
    logic                  r_ack;
    logic                  r_scl;
    logic                  r_sda;
    logic [NUM_PADS*W-1:0] r_buttons;
    logic [NUM_PADS-1:0]   r_present;
    logic                  r_valid;
    logic                  r_busy;

    logic       w_bit_state;
    logic       w_stall;
    logic       w_tick;
    logic       w_last_byte;
    logic       w_enter_stop;
    logic       w_txbit;
    logic [6:0] w_addr;
    logic [7:0] w_abyte;

    assign w_bit_state = (r_state == S_ADDR) || (r_state == S_AACK) ||
                         (r_state == S_RD)   || (r_state == S_MACK);
    // The sample phase waits for the pin to actually go high; the divider freezes with it.
    assign w_stall     = w_bit_state && (r_ph == 2'd2) && !scl_in;
    assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1)) && !w_stall;
    assign w_last_byte = (BYTES_PER_PAD == 1) || r_byte;
    assign w_addr      = BASE_ADDR + 7'(r_idx);
    assign w_abyte     = {w_addr, 1'b1};
    assign w_enter_stop = w_tick && (r_ph == 2'd3) && (r_bit == 3'd0) &&
                          (((r_state == S_AACK) && !r_ack) || ((r_state == S_MACK) && w_last_byte));

    always_comb begin
        w_txbit = 1'b1;
        case (r_state)
            S_ADDR:  w_txbit = w_abyte[r_bit];
            S_MACK:  w_txbit = w_last_byte;
            default: w_txbit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ph      <= 2'd0;
            r_bit     <= 3'd7;
            r_byte    <= 1'b0;
            r_idx     <= '0;
            r_div     <= '0;
            r_timer   <= '0;
            r_sr      <= '0;
            r_ack     <= 1'b0;
            r_scl     <= 1'b1;
            r_sda     <= 1'b1;
            r_buttons <= '0;
            r_present <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            if ((r_state == S_IDLE) && (r_timer == '0))
                r_timer <= TW'(POLL_PERIOD - 1);
            else if (r_timer != '0)
                r_timer <= r_timer - TW'(1);

            // Realigning the divider at each address phase keeps sweep length fixed.
            if ((r_state == S_IDLE) || (r_state == S_NEXT))
                r_div <= '0;
            else if (!w_stall)
                r_div <= (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + DIV_W'(1);

            if (w_enter_stop) begin
                r_present[r_idx]          <= r_ack;
                r_buttons[int'(r_idx)*W +: W] <= r_ack ? ~r_sr : '0;
            end

            case (r_state)
                S_IDLE: if (r_timer == '0) begin
                    r_state <= S_START;
                    r_ph    <= 2'd0;
                    r_busy  <= 1'b1;
                end
                S_START: if (w_tick) begin
                    if (r_ph == 2'd0) begin
                        r_sda <= 1'b0;
                        r_ph  <= 2'd1;
                    end else begin
                        r_scl   <= 1'b0;
                        r_ph    <= 2'd0;
                        r_bit   <= 3'd7;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR, S_AACK, S_RD, S_MACK: if (w_tick) begin
                    r_ph <= r_ph + 2'd1;
                    case (r_ph)
                        2'd0: r_sda <= w_txbit;
                        2'd1: r_scl <= 1'b1;
                        2'd2: begin
                            if (r_state == S_AACK) r_ack <= !sda_in;
                            if (r_state == S_RD)   r_sr  <= {r_sr[W-2:0], sda_in};
                        end
                        default: begin
                            r_scl <= 1'b0;
                            if (r_bit != 3'd0) begin
                                r_bit <= r_bit - 3'd1;
                            end else begin
                                case (r_state)
                                    S_ADDR: r_state <= S_AACK;
                                    S_AACK: begin
                                        r_state <= r_ack ? S_RD : S_STOP;
                                        r_bit   <= 3'd7;
                                        r_byte  <= 1'b0;
                                    end
                                    S_RD:   r_state <= S_MACK;
                                    default: begin
                                        r_state <= w_last_byte ? S_STOP : S_RD;
                                        r_bit   <= 3'd7;
                                        r_byte  <= r_byte + 1'b1;
                                    end
                                endcase
                            end
                        end
                    endcase
                end
                S_STOP: if (w_tick) begin
                    case (r_ph)
                        2'd0: begin r_sda <= 1'b0; r_ph <= 2'd1; end
                        2'd1: begin r_scl <= 1'b1; r_ph <= 2'd2; end
                        default: begin
                            r_sda   <= 1'b1;
                            r_ph    <= 2'd0;
                            r_state <= S_NEXT;
                        end
                    endcase
                end
                S_NEXT: begin
                    r_ph <= 2'd0;
                    if (r_idx == IDX_W'(NUM_PADS - 1)) begin
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= S_START;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign scl_out = r_scl;
    assign sda_out = r_sda;
    assign buttons = r_buttons;
    assign present = r_present;
    assign valid   = r_valid;
    assign busy    = r_busy;
endmodule

// File: tb/tb_joypad_poller.sv
// Directed bench: two pads at 0x7F and 0x00 (address wrap), two bytes each, back-to-back sweeps.
module tb_joypad_poller;
    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_out, sda_out, valid, busy;
    logic [31:0] buttons;
    logic [1:0]  present;
    logic        slave_scl = 1'b1;
    logic        slave_sda = 1'b1;
    logic        scl_line, sda_line;

    assign scl_line = scl_out & slave_scl;
    assign sda_line = sda_out & slave_sda;

    always #5 clk = ~clk;

    joypad_poller #(
        .CLK_DIV(C), .NUM_PADS(2), .BASE_ADDR(7'h7F), .BYTES_PER_PAD(2), .POLL_PERIOD(2)
    ) dut (
        .clk(clk), .rst(rst), .scl_in(scl_line), .sda_in(sda_line),
        .scl_out(scl_out), .sda_out(sda_out), .buttons(buttons),
        .present(present), .valid(valid), .busy(busy)
    );

    // Slave model configuration: which addresses answer, and their two data bytes.
    logic        acc0 = 1'b1, acc1 = 1'b0;
    logic [15:0] dat0 = 16'h7FFF, dat1 = 16'h1234;

    int          s_phase = 0, s_cnt = 0, s_byte = 0, pulses = 0;
    logic [7:0]  s_sr = 8'h00;
    logic [15:0] s_d;
    logic        p_scl = 1'b1, p_sda = 1'b1, sc, sd;
    logic [1:0]  mack_log = 2'b00;
    logic [6:0]  last_addr = 7'h55;
    logic        last_rw = 1'b0, last_aack = 1'b0;

    always @(negedge clk) begin
        sc = scl_line;
        sd = sda_line;
        if (rst) begin
            s_phase   = 0;
            slave_sda = 1'b1;
        end else if (sc && !p_scl) begin
            pulses++;
            if (s_phase == 1) begin
                if (s_cnt < 8) begin
                    s_sr = {s_sr[6:0], sd};
                    s_cnt++;
                end else begin
                    last_addr = s_sr[7:1];
                    last_rw   = s_sr[0];
                    last_aack = sd;
                    if (!sd) begin s_phase = 2; s_cnt = 0; s_byte = 0; end
                    else s_phase = 3;
                end
            end else if (s_phase == 2) begin
                if (s_cnt < 8) s_cnt++;
                else begin
                    mack_log[s_byte] = sd;
                    if (!sd) begin s_byte++; s_cnt = 0; end
                    else s_phase = 3;
                end
            end
        end else if (!sc && p_scl) begin
            s_d = (s_sr[7:1] == 7'h7F) ? dat0 : dat1;
            if (s_phase == 1)
                slave_sda = (s_cnt == 8 && ((s_sr[7:1] == 7'h7F && acc0) || (s_sr[7:1] == 7'h00 && acc1))) ? 1'b0 : 1'b1;
            else if (s_phase == 2 && s_cnt < 8)
                slave_sda = s_d[15 - 8*s_byte - s_cnt];
            else
                slave_sda = 1'b1;
        end else if (sc && p_scl && (sd !== p_sda)) begin
            s_phase   = sd ? 0 : 1;
            s_cnt     = 0;
            slave_sda = 1'b1;
        end
        p_scl = sc;
        p_sda = sd;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int n, p0;
        bit found;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_scl", scl_out, 1);
        chk("rst_sda", sda_out, 1);
        chk("rst_buttons", buttons, 0);
        chk("rst_present", present, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);

        rst = 1'b0;
        @(negedge clk);
        chk("busy_first_cycle", busy, 1);
        p0 = pulses;

        // Sweep 1: pad0 returns 7F,FF; pad1 (address wraps to 0x00) is absent.
        wait_valid("sw1", n);
        chk("sw1_buttons", buttons, 32'h0000_8000);
        chk("sw1_present", present, 2'b01);
        chk("sw1_busy", busy, 0);
        chk("sw1_master_ack", mack_log, 2'b10);
        chk("sw1_pad1_addr", last_addr, 7'h00);
        chk("sw1_pad1_rw", last_rw, 1);
        chk("sw1_pad1_nack", last_aack, 1);
        chk("sw1_scl_pulses", pulses - p0, 38);

        // Sweep 2: both pads present, starts immediately after sweep 1.
        acc1 = 1'b1; dat0 = 16'hFE00; dat1 = 16'h1234;
        p0 = pulses;
        wait_valid("sw2", n);
        chk("sw2_spacing", n, 3 + C*226);
        chk("sw2_buttons", buttons, 32'hEDCB_01FF);
        chk("sw2_present", present, 2'b11);
        chk("sw2_pad1_ack", last_aack, 0);
        chk("sw2_scl_pulses", pulses - p0, 56);

        // Sweep 3: slave stretches SCL on the fourth bit of pad0 byte 0; pad1 drops out.
        acc1 = 1'b0; dat0 = 16'hA53C;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (s_phase == 2 && s_cnt == 3 && s_byte == 0 && !scl_line) begin found = 1'b1; break; end
        end
        chk("stretch_point_seen", 32'(found), 1);
        slave_scl = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (scl_out) begin found = 1'b1; break; end
        end
        chk("stretch_master_release", 32'(found), 1);
        repeat (50) @(negedge clk);
        chk("stretch_scl_held", scl_out, 1);
        slave_scl = 1'b1;
        wait_valid("sw3", n);
        chk("sw3_buttons", buttons, 32'h0000_5AC3);
        chk("sw3_present", present, 2'b01);
        chk("sw3_master_ack", mack_log, 2'b10);

        // Sweep 4: reset in the middle of a read, then a fresh sweep.
        acc1 = 1'b1; dat0 = 16'h0001; dat1 = 16'h8000;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (s_phase == 2 && s_cnt == 4) begin found = 1'b1; break; end
        end
        chk("mid_read_seen", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_scl", scl_out, 1);
        chk("midrst_sda", sda_out, 1);
        chk("midrst_buttons", buttons, 0);
        chk("midrst_present", present, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_valid("sw5", n);
        chk("sw5_buttons", buttons, 32'h7FFF_FFFE);
        chk("sw5_present", present, 2'b11);
        wait_valid("sw6", n);
        chk("sw6_spacing", n, 3 + C*226);
        chk("sw6_buttons", buttons, 32'h7FFF_FFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
